// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: display modes, scan/breathe direction
// and the breathe brightness range.
package led_pkg;

   localparam int LEVEL_BITS = 4;
   localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;

   typedef enum logic [1:0] {
      MODE_BINARY  = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_FILL    = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle step strobe every CLK_HZ/TICK_HZ enabled cycles.
// step is combinational from the counter; clear restarts the count and suppresses the step.
module tick_prescaler #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_div_check
      $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
   end

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_top;

   assign w_at_top = (r_cnt == CNT_W'(DIV - 1));
   assign step     = enable && !clear && w_at_top;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= w_at_top ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// LED bank pattern generator: binary count, bouncing scan, PWM breathe and thermometer fill.
// LED and tick are registered; LED follows pattern state one clock after it changes.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 10,
   parameter int NUM_LEDS = 8,
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                mode_next,
   output logic [NUM_LEDS-1:0] LED,
   output logic [1:0]          mode,
   output logic                tick
);

   localparam int POS_W  = $clog2(NUM_LEDS);
   localparam int FILL_W = $clog2(NUM_LEDS + 1);

   if (NUM_LEDS < 2) begin : g_leds_check
      $error("led_pattern_gen: NUM_LEDS must be at least 2");
   end
   if (PWM_BITS < LEVEL_BITS) begin : g_pwm_check
      $error("led_pattern_gen: PWM_BITS must be at least 4");
   end

   mode_t                 r_mode,  w_mode;
   logic [NUM_LEDS-1:0]   r_count, w_count;
   logic [POS_W-1:0]      r_pos,   w_pos;
   dir_t                  r_dir,   w_dir;
   logic [LEVEL_BITS-1:0] r_level, w_level;
   logic [FILL_W-1:0]     r_fill,  w_fill;
   logic [PWM_BITS-1:0]   r_pwm;
   logic [NUM_LEDS-1:0]   r_led,   w_led;
   logic                  r_tick;
   logic                  w_step;

   tick_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .clear   (mode_next),
      .step    (w_step)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode  <= MODE_BINARY;
         r_count <= '0;
         r_pos   <= '0;
         r_dir   <= DIR_UP;
         r_level <= '0;
         r_fill  <= '0;
         r_pwm   <= '0;
         r_led   <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_mode  <= w_mode;
         r_count <= w_count;
         r_pos   <= w_pos;
         r_dir   <= w_dir;
         r_level <= w_level;
         r_fill  <= w_fill;
         r_pwm   <= r_pwm + PWM_BITS'(1);
         r_led   <= w_led;
         r_tick  <= w_step;
      end
   end

   // Only the active mode's state advances; a mode change restarts every pattern.
   always_comb begin
      w_mode  = r_mode;
      w_count = r_count;
      w_pos   = r_pos;
      w_dir   = r_dir;
      w_level = r_level;
      w_fill  = r_fill;
      if (mode_next) begin
         w_mode  = mode_t'(r_mode + 2'd1);
         w_count = '0;
         w_pos   = '0;
         w_dir   = DIR_UP;
         w_level = '0;
         w_fill  = '0;
      end else if (w_step) begin
         case (r_mode)
            MODE_BINARY: w_count = r_count + NUM_LEDS'(1);
            MODE_SCAN: begin
               if (r_dir == DIR_UP) begin
                  if (r_pos == POS_W'(NUM_LEDS - 1)) begin
                     w_dir = DIR_DOWN;
                     w_pos = POS_W'(NUM_LEDS - 2);
                  end else begin
                     w_pos = r_pos + POS_W'(1);
                  end
               end else if (r_pos == '0) begin
                  w_dir = DIR_UP;
                  w_pos = POS_W'(1);
               end else begin
                  w_pos = r_pos - POS_W'(1);
               end
            end
            MODE_BREATHE: begin
               if (r_dir == DIR_UP) begin
                  if (r_level == LEVEL_MAX) begin
                     w_dir   = DIR_DOWN;
                     w_level = LEVEL_MAX - LEVEL_BITS'(1);
                  end else begin
                     w_level = r_level + LEVEL_BITS'(1);
                  end
               end else if (r_level == '0) begin
                  w_dir   = DIR_UP;
                  w_level = LEVEL_BITS'(1);
               end else begin
                  w_level = r_level - LEVEL_BITS'(1);
               end
            end
            default: w_fill = (r_fill == FILL_W'(NUM_LEDS)) ? '0 : r_fill + FILL_W'(1);
         endcase
      end
   end

   always_comb begin
      w_led = '0;
      case (r_mode)
         MODE_BINARY: w_led = r_count;
         MODE_SCAN: begin
            for (int i = 0; i < NUM_LEDS; i++) w_led[i] = (r_pos == POS_W'(i));
         end
         MODE_BREATHE: w_led = {NUM_LEDS{r_pwm[PWM_BITS-1 -: LEVEL_BITS] < r_level}};
         default: begin
            for (int i = 0; i < NUM_LEDS; i++) w_led[i] = (FILL_W'(i) < r_fill);
         end
      endcase
   end

   assign LED  = r_led;
   assign mode = r_mode;
   assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen at CLK_HZ=100, TICK_HZ=10, NUM_LEDS=4, PWM_BITS=8.
module tb_led_pattern_gen;

   localparam int N   = 4;
   localparam int DIV = 10;

   logic         clk;
   logic         reset_n;
   logic         enable;
   logic         mode_next;
   logic [N-1:0] LED;
   logic [1:0]   mode;
   logic         tick;

   int checks = 0;
   int errors = 0;

   // Reference model: pattern is a pure function of steps taken since mode entry.
   int       m_phase, m_mode, m_k, m_pwm;
   logic     m_tick;
   logic [3:0] m_led;

   logic [3:0] seq[$];
   int         n_high, n_tick;

   led_pattern_gen #(
      .CLK_HZ   (100),
      .TICK_HZ  (10),
      .NUM_LEDS (N),
      .PWM_BITS (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .mode_next (mode_next),
      .LED       (LED),
      .mode      (mode),
      .tick      (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] led_of(input int md, input int k, input int pwm);
      int p;
      case (md)
         0: return 4'(k % 16);
         1: begin
            p = k % (2 * (N - 1));
            if (p > N - 1) p = 2 * (N - 1) - p;
            return 4'(1 << p);
         end
         2: begin
            p = k % 30;
            if (p > 15) p = 30 - p;
            return ((pwm / 16) < p) ? 4'hF : 4'h0;
         end
         default: begin
            p = k % (N + 1);
            return 4'((1 << p) - 1);
         end
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_mode = 0; m_k = 0; m_pwm = 0; m_tick = 1'b0; m_led = '0;
   endtask

   task automatic model_edge();
      logic [3:0] nl;
      logic       st;
      if (!reset_n) begin
         model_reset();
         return;
      end
      nl = led_of(m_mode, m_k, m_pwm);
      st = enable && !mode_next && (m_phase == DIV - 1);
      if (mode_next) begin
         m_mode = (m_mode + 1) % 4; m_k = 0; m_phase = 0;
      end else if (enable) begin
         if (m_phase == DIV - 1) begin
            m_phase = 0; m_k++;
         end else begin
            m_phase++;
         end
      end
      m_tick = st;
      m_pwm  = (m_pwm + 1) % 256;
      m_led  = nl;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("led", 32'(LED), 32'(m_led));
      check("mode", 32'(mode), 32'(m_mode));
      check("tick", 32'(tick), 32'(m_tick));
   endtask

   // Records the LED value shown right after each pattern step.
   task automatic run(input int n);
      logic prev;
      for (int i = 0; i < n; i++) begin
         prev = m_tick;
         cycle();
         if (prev) seq.push_back(LED);
         if (LED == 4'hF) n_high++;
         if (tick) n_tick++;
      end
   endtask

   task automatic pulse();
      mode_next = 1'b1;
      cycle();
      mode_next = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_scan [7];
      logic [3:0] exp_fill [5];
      logic [3:0] held;
      int         wait_n;
      exp_scan = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      exp_fill = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};

      reset_n = 1'b0; enable = 1'b0; mode_next = 1'b0;
      model_reset();
      #2;
      check("rst_led", 32'(LED), 32'h0);
      check("rst_mode", 32'(mode), 32'h0);
      check("rst_tick", 32'(tick), 32'h0);
      repeat (3) cycle();
      reset_n = 1'b1; enable = 1'b1;

      // Binary count: 17 ticks, LED 1..15 then wrap to 0.
      seq.delete(); n_tick = 0;
      run(170);
      check("bin_ticks", 32'(n_tick), 32'd17);
      check("bin_len", 32'(seq.size()), 32'd16);
      for (int i = 0; i < 16 && i < seq.size(); i++)
         check("bin_seq", 32'(seq[i]), 32'((i + 1) % 16));

      // Scan.
      pulse();
      cycle();
      check("scan_init", 32'(LED), 32'b0001);
      seq.delete();
      run(80);
      check("scan_len", 32'(seq.size()), 32'd8);
      for (int i = 0; i < 7 && i < seq.size(); i++)
         check("scan_seq", 32'(seq[i]), 32'(exp_scan[i]));

      // Breathe: dark at level 0, 50% duty at frozen level 8.
      pulse();
      n_high = 0;
      run(10);
      check("brth_lvl0", 32'(n_high), 32'd0);
      run(75);
      enable = 1'b0;
      n_high = 0;
      run(256);
      check("brth_lvl8", 32'(n_high), 32'd128);
      enable = 1'b1;

      // Fill.
      pulse();
      cycle();
      check("fill_init", 32'(LED), 32'b0000);
      seq.delete();
      run(50);
      check("fill_len", 32'(seq.size()), 32'd5);
      for (int i = 0; i < 5 && i < seq.size(); i++)
         check("fill_seq", 32'(seq[i]), 32'(exp_fill[i]));

      pulse();
      cycle();
      check("wrap_mode", 32'(mode), 32'd0);
      check("wrap_led", 32'(LED), 32'b0000);

      // Mode change on the same cycle the prescaler reaches its top.
      run(8);
      pulse();
      check("coinc_tick", 32'(tick), 32'd0);
      check("coinc_mode", 32'(mode), 32'd1);
      wait_n = 0;
      while (wait_n < 20) begin
         cycle();
         wait_n++;
         if (tick) break;
      end
      check("coinc_next", 32'(wait_n), 32'd10);

      // Freeze mid-scan.
      run(23);
      enable = 1'b0;
      held = m_led;
      n_tick = 0;
      for (int i = 0; i < 50; i++) begin
         cycle();
         check("hold_led", 32'(LED), 32'(held));
      end
      check("hold_ticks", 32'(n_tick), 32'd0);
      enable = 1'b1;
      run(40);

      // Random enable / mode_next traffic.
      for (int i = 0; i < 400; i++) begin
         enable    = ($urandom_range(0, 9) != 0);
         mode_next = ($urandom_range(0, 39) == 0);
         cycle();
      end
      mode_next = 1'b0; enable = 1'b1;

      // Async reset mid-fill.
      for (int i = 0; i < 4 && m_mode != 3; i++) pulse();
      run(25);
      #3 reset_n = 1'b0;
      #1;
      check("arst_led", 32'(LED), 32'h0);
      check("arst_mode", 32'(mode), 32'h0);
      check("arst_tick", 32'(tick), 32'h0);
      cycle();
      cycle();
      reset_n = 1'b1;
      for (int i = 0; i < 120; i++) begin
         enable    = ($urandom_range(0, 7) != 0);
         mode_next = ($urandom_range(0, 29) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator for the board LED bank. A prescaler derives a step tick from the system clock. Four selectable display modes drive NUM_LEDS outputs: binary count, bouncing scan, PWM breathe and thermometer fill. The block sits at top level between the 50 MHz board clock and the LED pins, with mode stepping from a debounced push-button pulse.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 10, pattern step rate in Hz; DIV = CLK_HZ/TICK_HZ, with DIV >= 2 enforced by elaboration check
NUM_LEDS, 8, LED count; must be >= 2
PWM_BITS, 8, PWM counter width for breathe mode; must be >= 4

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = patterns advance; 0 = pattern state frozen
mode_next  in  1  single-cycle pulse (already debounced/synchronised); advances mode
LED  out  NUM_LEDS  registered LED drive, 1 = on
mode  out  2  current mode: 0 BINARY, 1 SCAN, 2 BREATHE, 3 FILL
tick  out  1  registered one-cycle strobe on each pattern step

Behaviour:
- Reset (async assert, sync release): prescaler=0, mode=0, count=0, pos=0, dir=up, level=0, fill=0, pwm_cnt=0, LED=0, tick=0.
- Prescaler: runs 0..DIV-1 while enable=1. A step is generated when it equals DIV-1, and it wraps to 0 in that cycle. tick=1 in the following cycle. When enable=0 the prescaler holds and no steps occur.
- mode_next=1: mode <= mode+1 (3 wraps to 0). Same cycle: prescaler, count, pos, level and fill clear; dir=up. If mode_next and a step coincide, the mode change wins, the step is dropped and tick stays 0.
- BINARY: count (NUM_LEDS bits) +1 per step, wrapping at all-ones to 0. LED = count.
- SCAN: one-hot at pos. Moving up at pos=NUM_LEDS-1: dir<=down, pos<=NUM_LEDS-2. Moving down at pos=0: dir<=up, pos<=1. Otherwise pos +/- 1. Endpoints are shown for exactly one step.
- BREATHE: pwm_cnt (PWM_BITS) free-runs every clock, including when enable=0. level (4 bits) moves 0..15 and back, 1 per step, reversing at 15 and at 0. All LEDs = (pwm_cnt[PWM_BITS-1 -: 4] < level). level=0 means fully off.
- FILL: fill 0..NUM_LEDS, +1 per step; NUM_LEDS wraps to 0. LED = (1<<fill)-1, i.e. the low fill bits are set.
- LED latency: LED reflects the pattern state one clock after that state changes. After mode_next, the first cycle of LED reflects the cleared state of the new mode.
- enable=0 mid-pattern: LED holds its current value (breathe keeps PWM-ing at the frozen level). Re-enabling resumes from the held prescaler value.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package led_pkg: mode enum (MODE_BINARY=0, MODE_SCAN=1, MODE_BREATHE=2, MODE_FILL=3), LEVEL_BITS=4.
- One sub-module: tick_prescaler (params CLK_HZ, TICK_HZ; ports clk, reset_n, enable, clear, step). It is reused by future LED/UART blocks.
- Pattern state and output mux stay in led_pattern_gen.

Test Plan (CLK_HZ=100, TICK_HZ=10 so DIV=10, NUM_LEDS=4, PWM_BITS=8):
- Reset, enable=1, mode 0 for 170 clocks -> tick every 10 clocks; LED steps 0,1,2,..,15,0 (wrap after 16 steps).
- One mode_next pulse, then 80 clocks -> mode=1; LED sequence 0001,0010,0100,1000,0100,0010,0001,0010.
- A second mode_next pulse -> mode=2. Run until level=8, then sample 256 clocks -> LED high in exactly 128 clocks. At level=0, LED is always 0.
- A third mode_next pulse -> mode=3; LED 0000,0001,0011,0111,1111,0000 on successive steps. A fourth pulse -> mode=0, LED=0000.
- Assert mode_next on the same cycle as the prescaler reaching 9 -> no tick that cycle; mode advances; the next tick arrives 10 clocks later.
- enable=0 for 50 clocks mid-SCAN -> LED and pos unchanged, tick=0. Assert reset_n=0 asynchronously mid-FILL -> LED=0 and mode=0 without a clock edge.
